apb_bridge_nslv: RTL and testbench

//  Parametrised APB master bridging the LSU's APB-region accesses to NSLV peripherals (timer, uart, plic, ...).

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_slv_mux.sv | 54 +++++
 rtl/apb_bridge_nslv.sv | 199 +++++++++++++++++++
 tb/tb_apb_bridge_nslv.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared types and sizing helpers for the APB master bridge.
//   apb_state_e  : IDLE / SETUP / ACCESS bus phases.
//   slvIdxW()    : width of the slave index field (at least one bit).
//   waitCntW()   : width of the wait-state counter (holds 0..TIMEOUT).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int slvIdxW(input int nslv);
    return (nslv > 1) ? $clog2(nslv) : 1;
  endfunction

  function automatic int waitCntW(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// apb_slv_mux
//   Purely combinational slave decode and return-path multiplexer.
//   i_reqIdx    : slave index of the incoming request
//   o_reqSel    : one-hot select for that index
//   o_reqDecErr : index does not address an existing slave
//   i_curIdx    : registered index of the transfer in flight
//   i_pready/i_prdata/i_pslverr : per-slave return signals
//   o_ready/o_rdata/o_slverr    : return signals of the slave in flight
module apb_slv_mux
  import apb_pkg::*;
#(
  parameter int NSLV   = 3,
  parameter int DATA_W = 32,
  parameter int IDX_W  = slvIdxW(NSLV)
) (
  input  logic [IDX_W-1:0]       i_reqIdx,
  output logic [NSLV-1:0]        o_reqSel,
  output logic                   o_reqDecErr,
  input  logic [IDX_W-1:0]       i_curIdx,
  input  logic [NSLV-1:0]        i_pready,
  input  logic [NSLV*DATA_W-1:0] i_prdata,
  input  logic [NSLV-1:0]        i_pslverr,
  output logic                   o_ready,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_slverr
);

  // An index with no matching slave leaves the select empty and flags a decode error.
  always_comb begin
    o_reqSel    = '0;
    o_reqDecErr = 1'b1;
    for (int i = 0; i < NSLV; i++) begin
      if (i_reqIdx == IDX_W'(i)) begin
        o_reqSel[i] = 1'b1;
        o_reqDecErr = 1'b0;
      end
    end
  end

  // Only the slave owning the current transfer is listened to.
  always_comb begin
    o_ready  = 1'b0;
    o_rdata  = '0;
    o_slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (i_curIdx == IDX_W'(i)) begin
        o_ready  = i_pready[i];
        o_rdata  = i_prdata[i*DATA_W +: DATA_W];
        o_slverr = i_pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_bridge_nslv.sv
// apb_bridge_nslv
//   APB master bridging valid/ready CPU requests onto NSLV APB slaves.
//   pclk, preset_n              : clock, async active-low reset
//   req_valid/req_ready         : request handshake
//   req_addr/write/wdata/strb   : request payload
//   rsp_valid/rsp_rdata/rsp_err : one-cycle response pulse, data held between responses
//   psel/penable/pwrite/paddr/pwdata/pstrb : registered APB outputs
//   pready/prdata/pslverr       : per-slave APB returns
module apb_bridge_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int NSLV        = 3,
  parameter int SLV_SEL_LSB = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                   pclk,
  input  logic                   preset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_write,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_strb,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [31:0]            paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic [DATA_W/8-1:0]    pstrb,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int IDX_W  = slvIdxW(NSLV);
  localparam int CNT_W  = waitCntW(TIMEOUT);
  localparam int STRB_W = DATA_W / 8;

  apb_state_e        r_state;
  logic [NSLV-1:0]   r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [31:0]       r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              r_rspValid;
  logic              r_rspErr;
  logic [DATA_W-1:0] r_rspRdata;

  logic [IDX_W-1:0]  w_reqIdx;
  logic [NSLV-1:0]   w_reqSel;
  logic              w_reqDecErr;
  logic              w_curReady;
  logic [DATA_W-1:0] w_curRdata;
  logic              w_curSlverr;
  logic              w_reqReady;
  logic              w_accept;
  logic              w_load;
  logic              w_done;
  logic              w_abort;
  logic [CNT_W-1:0]  w_waitNext;

  assign w_reqIdx = req_addr[SLV_SEL_LSB +: IDX_W];

  apb_slv_mux #(
    .NSLV   (NSLV),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mux (
    .i_reqIdx    (w_reqIdx),
    .o_reqSel    (w_reqSel),
    .o_reqDecErr (w_reqDecErr),
    .i_curIdx    (r_idx),
    .i_pready    (pready),
    .i_prdata    (prdata),
    .i_pslverr   (pslverr),
    .o_ready     (w_curReady),
    .o_rdata     (w_curRdata),
    .o_slverr    (w_curSlverr)
  );

  // A decode-error request is held off during ACCESS: its immediate error
  // response would collide with the response of the completing transfer.
  always_comb begin
    w_reqReady = 1'b0;
    case (r_state)
      IDLE:    w_reqReady = 1'b1;
      ACCESS:  w_reqReady = w_curReady && !w_reqDecErr;
      default: w_reqReady = 1'b0;
    endcase
  end

  assign req_ready  = preset_n && w_reqReady;
  assign w_accept   = req_valid && req_ready;
  assign w_load     = w_accept && !w_reqDecErr;
  assign w_done     = (r_state == ACCESS) && w_curReady;
  assign w_waitNext = r_waitCnt + CNT_W'(1);
  // Abort on the TIMEOUT-th consecutive ACCESS cycle with pready low.
  assign w_abort    = (TIMEOUT > 0) && (r_state == ACCESS) && !w_curReady
                      && (w_waitNext == CNT_W'(TIMEOUT));

  // Address/data phase registers; they keep their last value while idle.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
      r_idx    <= '0;
    end else if (w_load) begin
      r_paddr  <= 32'(req_addr);
      r_pwrite <= req_write;
      r_pwdata <= req_wdata;
      r_pstrb  <= req_write ? req_strb : '0;
      r_idx    <= w_reqIdx;
    end
  end

  // Bus FSM with registered select/enable and response outputs.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state    <= IDLE;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_waitCnt  <= '0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_reqDecErr) begin
              r_rspValid <= 1'b1;
              r_rspErr   <= 1'b1;
              r_rspRdata <= '0;
            end else begin
              r_state <= SETUP;
              r_psel  <= w_reqSel;
            end
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
          r_waitCnt <= '0;
        end
        ACCESS: begin
          if (w_done) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= w_curSlverr;
            r_rspRdata <= (r_pwrite || w_curSlverr) ? '0 : w_curRdata;
            r_penable  <= 1'b0;
            if (w_load) begin
              r_state <= SETUP;
              r_psel  <= w_reqSel;
            end else begin
              r_state <= IDLE;
              r_psel  <= '0;
            end
          end else if (w_abort) begin
            r_rspValid <= 1'b1;
            r_rspErr   <= 1'b1;
            r_rspRdata <= '0;
            r_state    <= IDLE;
            r_psel     <= '0;
            r_penable  <= 1'b0;
          end else begin
            r_waitCnt <= w_waitNext;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_psel    <= '0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb_apb_bridge_nslv
//   Self-checking bench for apb_bridge_nslv (NSLV=3, SLV_SEL_LSB=8, TIMEOUT=4).
//   A transaction-level model predicts response latency, data, error and the
//   APB select/enable timeline for each request from its address, slave wait
//   states and error settings.
module tb_apb_bridge_nslv;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int NSLV        = 3;
  localparam int SLV_SEL_LSB = 8;
  localparam int TIMEOUT     = 4;

  logic                   pclk = 1'b0;
  logic                   preset_n;
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      req_addr;
  logic                   req_write;
  logic [DATA_W-1:0]      req_wdata;
  logic [DATA_W/8-1:0]    req_strb;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            paddr;
  logic [DATA_W-1:0]      pwdata;
  logic [DATA_W/8-1:0]    pstrb;
  logic [NSLV-1:0]        pready;
  logic [NSLV*DATA_W-1:0] prdata;
  logic [NSLV-1:0]        pslverr;

  int checkCount = 0;
  int errorCount = 0;

  always #5 pclk = ~pclk;

  apb_bridge_nslv #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .NSLV        (NSLV),
    .SLV_SEL_LSB (SLV_SEL_LSB),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives the slave side for one cycle: slave 'sel' gets the given values,
  // every other slave gets random noise that the bridge must ignore.
  task automatic applyStimulus(input int sel, input bit rdy, input logic [31:0] rd, input bit err);
    for (int i = 0; i < NSLV; i++) begin
      if (i == sel) begin
        pready[i]                   = rdy;
        prdata[i*DATA_W +: DATA_W]  = rd;
        pslverr[i]                  = err;
      end else begin
        pready[i]                   = 1'($urandom);
        prdata[i*DATA_W +: DATA_W]  = $urandom;
        pslverr[i]                  = 1'($urandom);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge pclk);
    #1;
  endtask

  // One isolated request; selected slave holds pready low for 'w' ACCESS cycles.
  task automatic runTxn(input logic [11:0] addr, input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input int w, input bit serr, input logic [31:0] rd);
    int          idx;
    bit          dec;
    int          lat;
    bit          expErr;
    logic [31:0] expRd;
    logic [2:0]  expSel;
    idx = int'(addr[9:8]);
    dec = (idx >= NSLV);
    if (dec) begin
      lat = 1; expErr = 1'b1; expRd = '0; expSel = '0;
    end else begin
      expSel = 3'(1 << idx);
      if (w < TIMEOUT) begin
        lat    = 3 + w;
        expErr = serr;
        expRd  = (!wr && !serr) ? rd : 32'h0;
      end else begin
        lat    = 2 + TIMEOUT;
        expErr = 1'b1;
        expRd  = '0;
      end
    end

    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_strb  = st;
    applyStimulus(-1, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("reqReadyIdle", req_ready, 1);
    checkOutput("rspQuietIdle", rsp_valid, 0);
    nextCycle();
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    req_write = 1'($urandom);
    req_wdata = $urandom;
    req_strb  = 4'($urandom);

    for (int k = 1; k <= lat + 1; k++) begin
      int j;
      j = k - 2;
      if (dec || k < 2)
        applyStimulus(dec ? -1 : idx, 1'($urandom), $urandom, 1'($urandom));
      else
        applyStimulus(idx, (j >= w), (j == w) ? rd : $urandom, (j == w) ? serr : 1'($urandom));
      #1;
      checkOutput($sformatf("rspValid a%0h k%0d", addr, k), rsp_valid, (k == lat));
      if (k == lat) begin
        checkOutput($sformatf("rspErr a%0h", addr), rsp_err, expErr);
        checkOutput($sformatf("rspRdata a%0h", addr), rsp_rdata, expRd);
      end
      checkOutput($sformatf("psel a%0h k%0d", addr, k), psel, (k < lat) ? expSel : 3'b000);
      checkOutput($sformatf("penable a%0h k%0d", addr, k), penable, (!dec && k >= 2 && k < lat));
      if (!dec && k == 1) begin
        checkOutput("reqReadySetup", req_ready, 0);
        checkOutput("paddr", paddr, {20'h0, addr});
        checkOutput("pwrite", pwrite, wr);
        checkOutput("pstrb", pstrb, wr ? st : 4'h0);
        if (wr) checkOutput("pwdata", pwdata, wd);
      end
      nextCycle();
    end
  endtask

  // Two reads back to back: the second is accepted on the first's completion cycle.
  task automatic runBackToBack();
    req_valid = 1'b1; req_addr = 12'h000; req_write = 1'b0; req_wdata = '0; req_strb = 4'hF;
    applyStimulus(-1, 1'b0, 32'h0, 1'b0);
    #1; checkOutput("b2bReady0", req_ready, 1);
    nextCycle();
    req_addr = 12'h200;
    applyStimulus(0, 1'($urandom), $urandom, 1'($urandom));
    #1;
    checkOutput("b2bSetupReady", req_ready, 0);
    checkOutput("b2bSetupSel", psel, 3'b001);
    checkOutput("b2bSetupEn", penable, 0);
    nextCycle();
    applyStimulus(0, 1'b1, 32'hA5A50001, 1'b0);
    #1;
    checkOutput("b2bAccessReady", req_ready, 1);
    checkOutput("b2bAccessEn", penable, 1);
    checkOutput("b2bAccessSel", psel, 3'b001);
    nextCycle();
    req_valid = 1'b0;
    applyStimulus(2, 1'($urandom), $urandom, 1'($urandom));
    #1;
    checkOutput("b2bRsp1Valid", rsp_valid, 1);
    checkOutput("b2bRsp1Data", rsp_rdata, 32'hA5A50001);
    checkOutput("b2bRsp1Err", rsp_err, 0);
    checkOutput("b2bSetup2Sel", psel, 3'b100);
    checkOutput("b2bSetup2En", penable, 0);
    checkOutput("b2bSetup2Addr", paddr, 32'h200);
    nextCycle();
    applyStimulus(2, 1'b1, 32'h5A5A0002, 1'b0);
    #1;
    checkOutput("b2bAccess2Rsp", rsp_valid, 0);
    checkOutput("b2bAccess2En", penable, 1);
    checkOutput("b2bAccess2Sel", psel, 3'b100);
    nextCycle();
    applyStimulus(-1, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("b2bRsp2Valid", rsp_valid, 1);
    checkOutput("b2bRsp2Data", rsp_rdata, 32'h5A5A0002);
    checkOutput("b2bIdleSel", psel, 3'b000);
    checkOutput("b2bIdleEn", penable, 0);
    nextCycle();
    checkOutput("b2bRspDone", rsp_valid, 0);
  endtask

  // Reset asserted in the middle of ACCESS drops the transfer without a response.
  task automatic runResetMidAccess();
    req_valid = 1'b1; req_addr = 12'h104; req_write = 1'b0; req_wdata = '0; req_strb = '0;
    applyStimulus(-1, 1'b0, 32'h0, 1'b0);
    nextCycle();
    req_valid = 1'b0;
    applyStimulus(1, 1'b0, 32'h0, 1'b0);
    nextCycle();
    #1;
    checkOutput("rstPreEn", penable, 1);
    preset_n = 1'b0;
    #1;
    checkOutput("rstSel", psel, 3'b000);
    checkOutput("rstEn", penable, 0);
    checkOutput("rstRsp", rsp_valid, 0);
    checkOutput("rstAddr", paddr, 32'h0);
    checkOutput("rstReady", req_ready, 0);
    nextCycle();
    preset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1'b1, $urandom, 1'b0);
      #1;
      checkOutput($sformatf("rstNoRsp k%0d", k), rsp_valid, 0);
      checkOutput($sformatf("rstNoSel k%0d", k), psel, 3'b000);
      nextCycle();
    end
  endtask

  initial begin
    preset_n  = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    applyStimulus(-1, 1'b0, 32'h0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("resetSel", psel, 3'b000);
    checkOutput("resetEn", penable, 0);
    checkOutput("resetRsp", rsp_valid, 0);
    checkOutput("resetRdata", rsp_rdata, 32'h0);
    checkOutput("resetErr", rsp_err, 0);
    checkOutput("resetAddr", paddr, 32'h0);
    checkOutput("resetPwdata", pwdata, 32'h0);
    checkOutput("resetPstrb", pstrb, 4'h0);
    checkOutput("resetPwrite", pwrite, 0);
    checkOutput("resetReady", req_ready, 0);
    preset_n = 1'b1;
    nextCycle();

    runTxn(12'h104, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    runTxn(12'h008, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'h12345678);
    runBackToBack();
    runTxn(12'h300, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hFFFFFFFF);
    runTxn(12'h104, 1'b0, 32'h0, 4'h0, 99, 1'b0, 32'h11111111);
    runTxn(12'h0A0, 1'b0, 32'h0, 4'h0, 1, 1'b1, 32'h22222222);
    runTxn(12'h210, 1'b1, 32'hCAFEF00D, 4'h5, 3, 1'b0, 32'h0);
    runResetMidAccess();
    runTxn(12'h104, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h87654321);

    for (int n = 0; n < 40; n++) begin
      runTxn(12'($urandom), 1'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 5)), 1'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
